key_extract_sched: RTL and testbench

KEY_EXTRACT_SCHED -- requirements
Module: key_extract_sched

---
 rtl/key_extract_sched.sv | 192 +++++++++++++++++++
 tb/tb_key_extract_sched.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_extract_sched.sv
// rtl/key_extract_sched.sv - two-port PHV scheduler feeding a key extractor from a per-VLAN key table
// Optional build macro: KEY_SCHED_STRICT_PRIO_EN (strict port-0 priority instead of round-robin)
module key_extract_sched #(
    parameter int PHV_LEN        = 1024,
    parameter int KEY_LEN        = 193,
    parameter int KEY_OFF        = 38,
    parameter int C_VLANID_WIDTH = 12,
    parameter int TBL_AW         = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic [PHV_LEN-1:0]        phv0_in,
    input  logic                      phv0_valid_in,
    input  logic [C_VLANID_WIDTH-1:0] phv0_vlan_in,
    output logic                      phv0_ready_out,

    input  logic [PHV_LEN-1:0]        phv1_in,
    input  logic                      phv1_valid_in,
    input  logic [C_VLANID_WIDTH-1:0] phv1_vlan_in,
    output logic                      phv1_ready_out,

    input  logic                      cfg_wr_en,
    input  logic [TBL_AW-1:0]         cfg_wr_addr,
    input  logic [KEY_OFF-1:0]        cfg_wr_offset,
    input  logic [KEY_LEN-1:0]        cfg_wr_mask,

    input  logic                      ext_ready_in,

    output logic [PHV_LEN-1:0]        phv_out,
    output logic                      phv_valid_out,
    output logic                      key_offset_valid,
    output logic [KEY_OFF-1:0]        key_offset_w,
    output logic [KEY_LEN-1:0]        key_mask_w,

    output logic                      grant_src_out,
    output logic [31:0]               cnt_port0,
    output logic [31:0]               cnt_port1
);

    localparam int TBL_DEPTH = 1 << TBL_AW;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } state_t;

    state_t state;

    // Per-port holding registers; only the table-index bits of the VLAN are kept
    logic [PHV_LEN-1:0] hold0_phv;
    logic [PHV_LEN-1:0] hold1_phv;
    logic [TBL_AW-1:0]  hold0_idx;
    logic [TBL_AW-1:0]  hold1_idx;
    logic               hold0_full;
    logic               hold1_full;

    logic [KEY_OFF-1:0] tbl_off  [TBL_DEPTH];
    logic [KEY_LEN-1:0] tbl_mask [TBL_DEPTH];

`ifndef KEY_SCHED_STRICT_PRIO_EN
    // Port issued most recently; resets to 1 so port 0 wins the first contention
    logic last_grant;
`endif

    logic              any_full;
    logic              issue;
    logic              winner;
    logic [TBL_AW-1:0] win_idx;

    // VLAN bits above the table index never influence the lookup
    generate
        if (C_VLANID_WIDTH > TBL_AW) begin : g_vlan_hi
            logic unused_vlan_hi;
            assign unused_vlan_hi = ^{phv0_vlan_in[C_VLANID_WIDTH-1:TBL_AW],
                                      phv1_vlan_in[C_VLANID_WIDTH-1:TBL_AW]};
        end
    endgenerate

    assign phv0_ready_out = ~hold0_full;
    assign phv1_ready_out = ~hold1_full;

    // Decide whether a PHV issues this cycle and which port it comes from
    always_comb begin
        any_full = hold0_full | hold1_full;
        issue    = (state == IDLE) && ext_ready_in && any_full;
`ifdef KEY_SCHED_STRICT_PRIO_EN
        winner   = ~hold0_full;
`else
        if (hold0_full && hold1_full) begin
            winner = ~last_grant;
        end else begin
            winner = ~hold0_full;
        end
`endif
        win_idx  = winner ? hold1_idx : hold0_idx;
    end

    // Port 0 holding register: fill when empty, drain when it wins an issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold0_full <= 1'b0;
            hold0_phv  <= '0;
            hold0_idx  <= '0;
        end else if (phv0_valid_in && !hold0_full) begin
            hold0_full <= 1'b1;
            hold0_phv  <= phv0_in;
            hold0_idx  <= phv0_vlan_in[TBL_AW-1:0];
        end else if (issue && !winner) begin
            hold0_full <= 1'b0;
        end
    end

    // Port 1 holding register: fill when empty, drain when it wins an issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold1_full <= 1'b0;
            hold1_phv  <= '0;
            hold1_idx  <= '0;
        end else if (phv1_valid_in && !hold1_full) begin
            hold1_full <= 1'b1;
            hold1_phv  <= phv1_in;
            hold1_idx  <= phv1_vlan_in[TBL_AW-1:0];
        end else if (issue && winner) begin
            hold1_full <= 1'b0;
        end
    end

    // Key table write port; a same-edge lookup still sees the old entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                tbl_off[i]  <= '0;
                tbl_mask[i] <= '0;
            end
        end else if (cfg_wr_en) begin
            tbl_off[cfg_wr_addr]  <= cfg_wr_offset;
            tbl_mask[cfg_wr_addr] <= cfg_wr_mask;
        end
    end

    // Issue FSM: one IDLE cycle to issue, one GAP cycle carrying the registered feed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            phv_out          <= '0;
            phv_valid_out    <= 1'b0;
            key_offset_valid <= 1'b0;
            key_offset_w     <= '0;
            key_mask_w       <= '0;
            grant_src_out    <= 1'b0;
            cnt_port0        <= '0;
            cnt_port1        <= '0;
`ifndef KEY_SCHED_STRICT_PRIO_EN
            last_grant       <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state            <= GAP;
                        phv_out          <= winner ? hold1_phv : hold0_phv;
                        key_offset_w     <= tbl_off[win_idx];
                        key_mask_w       <= tbl_mask[win_idx];
                        grant_src_out    <= winner;
                        phv_valid_out    <= 1'b1;
                        key_offset_valid <= 1'b1;
`ifndef KEY_SCHED_STRICT_PRIO_EN
                        last_grant       <= winner;
`endif
                        if (winner) begin
                            cnt_port1 <= cnt_port1 + 32'd1;
                        end else begin
                            cnt_port0 <= cnt_port0 + 32'd1;
                        end
                    end
                end
                GAP: begin
                    state            <= IDLE;
                    phv_valid_out    <= 1'b0;
                    key_offset_valid <= 1'b0;
                end
                default: begin
                    state            <= IDLE;
                    phv_valid_out    <= 1'b0;
                    key_offset_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_extract_sched.sv
// tb/tb_key_extract_sched.sv - randomized and directed self-checking bench for key_extract_sched
`timescale 1ns/1ps
module tb_key_extract_sched;

    localparam int PHV_LEN = 1024;
    localparam int KEY_LEN = 193;
    localparam int KEY_OFF = 38;
    localparam int VW      = 12;
    localparam int TBL_AW  = 4;
    localparam int DEPTH   = 16;
`ifdef KEY_SCHED_STRICT_PRIO_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [PHV_LEN-1:0] phv0_in = '0, phv1_in = '0;
    logic               phv0_valid_in = 1'b0, phv1_valid_in = 1'b0;
    logic [VW-1:0]      phv0_vlan_in = '0, phv1_vlan_in = '0;
    logic               phv0_ready_out, phv1_ready_out;
    logic               cfg_wr_en = 1'b0;
    logic [TBL_AW-1:0]  cfg_wr_addr = '0;
    logic [KEY_OFF-1:0] cfg_wr_offset = '0;
    logic [KEY_LEN-1:0] cfg_wr_mask = '0;
    logic               ext_ready_in = 1'b1;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_valid_out, key_offset_valid;
    logic [KEY_OFF-1:0] key_offset_w;
    logic [KEY_LEN-1:0] key_mask_w;
    logic               grant_src_out;
    logic [31:0]        cnt_port0, cnt_port1;

    always #5 clk = ~clk;

    key_extract_sched #(
        .PHV_LEN(PHV_LEN), .KEY_LEN(KEY_LEN), .KEY_OFF(KEY_OFF),
        .C_VLANID_WIDTH(VW), .TBL_AW(TBL_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .phv0_in(phv0_in), .phv0_valid_in(phv0_valid_in), .phv0_vlan_in(phv0_vlan_in), .phv0_ready_out(phv0_ready_out),
        .phv1_in(phv1_in), .phv1_valid_in(phv1_valid_in), .phv1_vlan_in(phv1_vlan_in), .phv1_ready_out(phv1_ready_out),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_offset(cfg_wr_offset), .cfg_wr_mask(cfg_wr_mask),
        .ext_ready_in(ext_ready_in),
        .phv_out(phv_out), .phv_valid_out(phv_valid_out), .key_offset_valid(key_offset_valid),
        .key_offset_w(key_offset_w), .key_mask_w(key_mask_w),
        .grant_src_out(grant_src_out), .cnt_port0(cnt_port0), .cnt_port1(cnt_port1)
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;
    bit cmp_en   = 1'b0;

    // Reference model: each port is a one-slot mailbox, the table is a plain array,
    // and after any issue the scheduler must sit out one cycle.
    bit                 m_full [2];
    logic [PHV_LEN-1:0] m_phv  [2];
    int                 m_idx  [2];
    logic [KEY_OFF-1:0] m_off  [DEPTH];
    logic [KEY_LEN-1:0] m_mask [DEPTH];
    bit                 m_busy;
    int                 m_last;
    bit                 e_valid;
    logic [PHV_LEN-1:0] e_phv;
    logic [KEY_OFF-1:0] e_off;
    logic [KEY_LEN-1:0] e_mask;
    int                 e_grant;
    logic [31:0]        e_cnt [2];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_phv(input string name, input logic [PHV_LEN-1:0] act, input logic [PHV_LEN-1:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got low64 %0h expected low64 %0h at %0t", name, act[63:0], exp[63:0], $time);
    endtask

    function automatic logic [PHV_LEN-1:0] rnd_phv();
        logic [PHV_LEN-1:0] v;
        for (int i = 0; i < PHV_LEN / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [KEY_LEN-1:0] rnd_mask();
        logic [223:0] v;
        for (int i = 0; i < 7; i++) v[i*32 +: 32] = $urandom();
        return v[KEY_LEN-1:0];
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_full[p] = 1'b0; m_phv[p] = '0; m_idx[p] = 0; e_cnt[p] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            m_off[i] = '0; m_mask[i] = '0;
        end
        m_busy = 1'b0; m_last = 1; e_valid = 1'b0; e_phv = '0; e_off = '0; e_mask = '0; e_grant = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs present at the edge
    task automatic model_step();
        bit was_empty [2];
        int w;
        bit go;
        was_empty[0] = !m_full[0];
        was_empty[1] = !m_full[1];
        go = !m_busy && ext_ready_in && (m_full[0] || m_full[1]);
        if (m_full[0] && m_full[1]) w = STRICT ? 0 : (m_last == 0 ? 1 : 0);
        else w = m_full[0] ? 0 : 1;
        e_valid = go;
        if (go) begin
            e_phv   = m_phv[w];
            e_off   = m_off[m_idx[w]];
            e_mask  = m_mask[m_idx[w]];
            e_grant = w;
            e_cnt[w] = e_cnt[w] + 32'd1;
            m_full[w] = 1'b0;
            m_last = w;
        end
        m_busy = go;
        if (was_empty[0] && phv0_valid_in) begin
            m_full[0] = 1'b1; m_phv[0] = phv0_in; m_idx[0] = int'(phv0_vlan_in) % DEPTH;
        end
        if (was_empty[1] && phv1_valid_in) begin
            m_full[1] = 1'b1; m_phv[1] = phv1_in; m_idx[1] = int'(phv1_vlan_in) % DEPTH;
        end
        if (cfg_wr_en) begin
            m_off[cfg_wr_addr]  = cfg_wr_offset;
            m_mask[cfg_wr_addr] = cfg_wr_mask;
        end
    endtask

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("phv_valid_out", phv_valid_out, e_valid);
            chk("key_offset_valid", key_offset_valid, e_valid);
            chk("phv0_ready_out", phv0_ready_out, !m_full[0]);
            chk("phv1_ready_out", phv1_ready_out, !m_full[1]);
            chk("cnt_port0", cnt_port0, e_cnt[0]);
            chk("cnt_port1", cnt_port1, e_cnt[1]);
            if (e_valid) begin
                chk_phv("phv_out", phv_out, e_phv);
                chk("key_offset_w", key_offset_w, e_off);
                chk("key_mask_w", key_mask_w, e_mask);
                chk("grant_src_out", grant_src_out, e_grant[0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_idle();
        phv0_valid_in = 1'b0; phv1_valid_in = 1'b0; cfg_wr_en = 1'b0; ext_ready_in = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        set_idle();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int grants [8];
    int cycs   [8];
    int n_iss;
    logic [31:0] c0_at8, c1_at8;

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("reset_valid", phv_valid_out, 1'b0);
        chk("reset_ready0", phv0_ready_out, 1'b1);
        chk("reset_ready1", phv1_ready_out, 1'b1);
        chk("reset_cnt0", cnt_port0, 32'd0);
        cmp_en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;

        // Single PHV through a programmed table entry
        cfg_wr_en = 1'b1; cfg_wr_addr = 4'd3; cfg_wr_offset = 38'h2A5A5A5A5A; cfg_wr_mask = '0;
        tick();
        cfg_wr_en = 1'b0;
        phv0_valid_in = 1'b1; phv0_vlan_in = 12'h003; phv0_in = rnd_phv();
        tick();
        chk("req028_ready0_low", phv0_ready_out, 1'b0);
        chk("req028_not_yet", phv_valid_out, 1'b0);
        phv0_valid_in = 1'b0;
        tick();
        chk("req028_valid", phv_valid_out, 1'b1);
        chk("req028_offset", key_offset_w, 38'h2A5A5A5A5A);
        chk("req028_grant", grant_src_out, 1'b0);
        chk("req028_ready0_back", phv0_ready_out, 1'b1);
        tick();
        chk("req028_one_cycle", phv_valid_out, 1'b0);

        // Both ports saturated for 8 issues
        do_reset();
        n_iss = 0;
        phv0_valid_in = 1'b1; phv1_valid_in = 1'b1;
        for (int c = 0; c < 40 && n_iss < 8; c++) begin
            phv0_in = rnd_phv(); phv1_in = rnd_phv();
            phv0_vlan_in = VW'($urandom_range(0, 4095)); phv1_vlan_in = VW'($urandom_range(0, 4095));
            tick();
            if (phv_valid_out) begin
                grants[n_iss] = int'(grant_src_out);
                cycs[n_iss] = c;
                if (n_iss == 7) begin
                    c0_at8 = cnt_port0; c1_at8 = cnt_port1;
                end
                n_iss++;
            end
        end
        set_idle();
        chk("req029_issue_count", n_iss, 8);
        if (n_iss == 8) begin
            for (int i = 0; i < 8; i++) chk($sformatf("req029_grant%0d", i), grants[i], STRICT ? 0 : (i % 2));
            for (int i = 1; i < 8; i++) chk($sformatf("req029_spacing%0d", i), cycs[i] - cycs[i-1], 2);
            chk("req029_cnt0", c0_at8, STRICT ? 32'd8 : 32'd4);
            chk("req029_cnt1", c1_at8, STRICT ? 32'd0 : 32'd4);
        end

        // Table write colliding with a lookup of the same entry
        do_reset();
        cfg_wr_en = 1'b1; cfg_wr_addr = 4'd5; cfg_wr_offset = 38'h11_2233_4455; cfg_wr_mask = 193'h1_0000_0000_0000_00AB;
        tick();
        cfg_wr_en = 1'b0;
        phv0_valid_in = 1'b1; phv0_vlan_in = 12'h105; phv0_in = rnd_phv();
        tick();
        phv0_valid_in = 1'b0;
        cfg_wr_en = 1'b1; cfg_wr_offset = 38'h30_0000_BEEF; cfg_wr_mask = 193'hFACE;
        tick();
        cfg_wr_en = 1'b0;
        chk("req030_old_offset", key_offset_w, 38'h11_2233_4455);
        chk("req030_old_mask", key_mask_w, 193'h1_0000_0000_0000_00AB);
        tick();
        phv0_valid_in = 1'b1; phv0_vlan_in = 12'h005; phv0_in = rnd_phv();
        tick();
        phv0_valid_in = 1'b0;
        tick();
        chk("req030_new_offset", key_offset_w, 38'h30_0000_BEEF);
        chk("req030_new_mask", key_mask_w, 193'hFACE);

        // Extractor back-pressure with both ports full
        do_reset();
        ext_ready_in = 1'b0;
        phv0_valid_in = 1'b1; phv1_valid_in = 1'b1; phv0_in = rnd_phv(); phv1_in = rnd_phv();
        tick();
        phv0_valid_in = 1'b0; phv1_valid_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("req031_no_valid", phv_valid_out, 1'b0);
            chk("req031_ready0", phv0_ready_out, 1'b0);
            chk("req031_ready1", phv1_ready_out, 1'b0);
        end
        ext_ready_in = 1'b1;
        tick();
        chk("req031_release_valid", phv_valid_out, 1'b1);
        chk("req031_release_grant", grant_src_out, 1'b0);

        // Asynchronous reset during the GAP cycle
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("req032_valid", phv_valid_out, 1'b0);
        chk("req032_kov", key_offset_valid, 1'b0);
        chk_phv("req032_phv", phv_out, '0);
        chk("req032_cnt0", cnt_port0, 32'd0);
        chk("req032_ready1", phv1_ready_out, 1'b1);
        set_idle();
        tick();
        rst_n = 1'b1;
        chk("req032_ready0_after", phv0_ready_out, 1'b1);
        chk("req032_ready1_after", phv1_ready_out, 1'b1);
        tick();
        tick();
        chk("req032_held_lost", phv_valid_out, 1'b0);

        // Randomized traffic, table writes, back-pressure and one mid-run reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            phv0_valid_in = ($urandom_range(0, 9) < 6);
            phv1_valid_in = ($urandom_range(0, 9) < 6);
            phv0_in = rnd_phv(); phv1_in = rnd_phv();
            phv0_vlan_in = VW'($urandom_range(0, 4095)); phv1_vlan_in = VW'($urandom_range(0, 4095));
            ext_ready_in = ($urandom_range(0, 3) != 0);
            cfg_wr_en = ($urandom_range(0, 4) == 0);
            cfg_wr_addr = TBL_AW'($urandom_range(0, DEPTH - 1));
            cfg_wr_offset = {6'($urandom()), 32'($urandom())};
            cfg_wr_mask = rnd_mask();
            if (c == 1500) do_reset();
            else tick();
        end
        set_idle();
        tick();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
